// File: rtl/qspi_line_reader_pkg.sv
// Shared constants and types for the QSPI line reader: flash opcodes, FSM
// encoding, io0 direction values and the bank write request.
package qspi_line_reader_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'h6B;

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       en;
    logic       quad;
    logic [3:0] data;
  } wr_req_t;

  function automatic logic [7:0] cmd_code(input logic q);
    return q ? CMD_QREAD : CMD_READ;
  endfunction

endpackage

// File: rtl/qspi_line_bank.sv
// Ping-pong line storage: fill side written on the falling clk edge, display
// side read through a registered port.
module qspi_line_bank
  import qspi_line_reader_pkg::*;
#(
  parameter int BUF_BITS = 136,
  parameter int IDX_W    = $clog2(BUF_BITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  wr_req_t          wr,
  input  logic [IDX_W-1:0] wr_cnt,
  input  logic             swap,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_data
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(BUF_BITS - 1);

  logic [1:0][BUF_BITS-1:0] bank;
  logic                     disp;
  logic [IDX_W-1:0]         wr_bit;

  // First received bit/nibble lands at the top of the line.
  assign wr_bit = TOP - (wr.quad ? {wr_cnt[IDX_W-3:0], 2'b00} : wr_cnt);

  always_ff @(negedge clk) begin
    if (wr.en) begin
      if (wr.quad) bank[~disp][wr_bit -: 4] <= wr.data;
      else         bank[~disp][wr_bit]      <= wr.data[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp    <= 1'b0;
      rd_data <= 1'b0;
    end else begin
      if (swap) disp <= ~disp;
      rd_data <= ({1'b0, rd_index} < (IDX_W+1)'(BUF_BITS)) ? bank[disp][rd_index] : 1'b0;
    end
  end

endmodule

// File: rtl/qspi_line_reader.sv
// QSPI flash line fetcher: sends 03h/6Bh + address, streams one line into the
// fill bank, then swaps banks so the display side always holds a whole line.
module qspi_line_reader
  import qspi_line_reader_pkg::*;
#(
  parameter int BUF_BITS     = 136,
  parameter int DUMMY_CYCLES = 8,
  parameter int ADDR_BITS    = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        quad,
  input  logic [ADDR_BITS-1:0]        addr,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  input  logic [$clog2(BUF_BITS)-1:0] rd_index,
  output logic                        rd_data,
  output logic                        spi_cs,
  output logic                        spi_sclk,
  input  logic [3:0]                  spi_in,
  output logic                        spi_out0,
  output logic                        spi_dir0
);

  localparam int IDX_W = $clog2(BUF_BITS);
  localparam int CNT_W = $clog2(BUF_BITS + ADDR_BITS + DUMMY_CYCLES + 8);
  localparam int SH_W  = 8 + ADDR_BITS;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_last;
  logic [SH_W-1:0]  sh;
  logic             quad_r;
  logic             cs_nx, dir_nx, busy_nx, done_nx;
  wr_req_t          wr;

  assign spi_sclk = ~clk;
  assign spi_out0 = (state == ST_CMD || state == ST_ADDR) ? sh[SH_W-1] : 1'b0;

  always_comb begin
    cnt_last = '0;
    case (state)
      ST_CMD:   cnt_last = CNT_W'(7);
      ST_ADDR:  cnt_last = CNT_W'(ADDR_BITS - 1);
      ST_DUMMY: cnt_last = CNT_W'(DUMMY_CYCLES - 1);
      ST_DATA:  cnt_last = quad_r ? CNT_W'(BUF_BITS/4 - 1) : CNT_W'(BUF_BITS - 1);
      default:  cnt_last = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == ST_IDLE) begin
      // start beats a simultaneous abort here: abort only acts on a fetch
      if (start) begin
        state_nx = ST_CMD;
        cnt_nx   = '0;
      end
    end else if (state == ST_DONE) begin
      state_nx = ST_IDLE;
    end else if (abort) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else if (cnt != cnt_last) begin
      cnt_nx = cnt + CNT_W'(1);
    end else begin
      cnt_nx = '0;
      case (state)
        ST_CMD:   state_nx = ST_ADDR;
        ST_ADDR:  state_nx = (quad_r && DUMMY_CYCLES > 0) ? ST_DUMMY : ST_DATA;
        ST_DUMMY: state_nx = ST_DATA;
        default:  state_nx = ST_DONE;
      endcase
    end
    cs_nx   = state_nx inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    dir_nx  = (state_nx inside {ST_DUMMY, ST_DATA}) ? DIR_IN : DIR_OUT;
    busy_nx = state_nx != ST_IDLE;
    done_nx = state_nx == ST_DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sh       <= '0;
      quad_r   <= 1'b0;
      spi_cs   <= 1'b0;
      spi_dir0 <= DIR_OUT;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      spi_cs   <= cs_nx;
      spi_dir0 <= dir_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      if (state == ST_IDLE && start) begin
        sh     <= {cmd_code(quad), addr};
        quad_r <= quad;
      end else if (state == ST_CMD || state == ST_ADDR) begin
        sh <= {sh[SH_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    wr      = '0;
    wr.en   = state == ST_DATA;
    wr.quad = quad_r;
    wr.data = spi_in;
  end

  // Swap on entry to DONE so the fresh line is visible while done is high.
  qspi_line_bank #(.BUF_BITS(BUF_BITS), .IDX_W(IDX_W)) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .wr_cnt   (cnt[IDX_W-1:0]),
    .swap     (state_nx == ST_DONE),
    .rd_index (rd_index),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_qspi_line_reader.sv
// Bench for qspi_line_reader: flash model plus scoreboard of bus transactions
// and a two-bank reference of what the display side must hold.
module tb_qspi_line_reader;

  localparam int BB = 136;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, quad = 1'b0, abort = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  rd_index = '0;
  logic [3:0]  spi_in = '0;
  logic        busy, done, rd_data, spi_cs, spi_sclk, spi_out0, spi_dir0;

  qspi_line_reader dut (
    .clk(clk), .reset(reset), .start(start), .quad(quad), .addr(addr),
    .abort(abort), .busy(busy), .done(done), .rd_index(rd_index),
    .rd_data(rd_data), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_in(spi_in),
    .spi_out0(spi_out0), .spi_dir0(spi_dir0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          len;
    int          dr;
    bit          dn;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0, fails = 0;
  int          done_seen = 0, exp_done = 0, idle_err = 0;
  logic [BB-1:0] flash_pat;
  logic [BB-1:0] mbank[2];
  bit          mknown[2];
  int          mdisp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BB-1:0] rand_pat();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[BB-1:0];
  endfunction

  // Flash model and bus monitor: one observation per cycle, #1 after posedge.
  initial begin : mon
    bit          act;
    int          cyc, k, dr, gaps, n;
    logic [31:0] w;
    logic [7:0]  fcmd;
    logic [3:0]  nib;
    exp_t        e;
    act = 0; cyc = 0; dr = -1; gaps = 0; w = '0; fcmd = '0;
    forever begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
      if (spi_cs === 1'b1) begin
        if (!act) begin act = 1; cyc = 0; w = '0; dr = -1; gaps = 0; fcmd = '0; end
        else cyc++;
        if (cyc < 32) w = {w[30:0], spi_out0};
        if (cyc == 7) fcmd = w[7:0];
        if (spi_dir0 === 1'b1 && dr < 0) dr = cyc;
        if (busy !== 1'b1) gaps++;
        k = cyc - ((fcmd == 8'h6B) ? 40 : 32);
        if (cyc >= 8 && fcmd == 8'h6B && k >= 0 && k < BB/4) begin
          nib = flash_pat[BB-1-4*k -: 4];
          spi_in = nib;
        end else if (cyc >= 8 && fcmd == 8'h03 && k >= 0 && k < BB) begin
          spi_in = {2'($urandom), flash_pat[BB-1-k], 1'($urandom)};
        end else begin
          spi_in = 4'($urandom);
        end
      end else begin
        spi_in = 4'($urandom);
        if (spi_out0 !== 1'b0 || spi_dir0 !== 1'b0) idle_err++;
        if (act) begin
          act = 0;
          if (sbq.size() == 0) chk("unexpected_fetch", 1, 0);
          else begin
            e = sbq.pop_front();
            n = (cyc + 1 < 32) ? cyc + 1 : 32;
            chk("mosi_cmd_addr", w, e.word >> (32 - n));
            chk("cs_len", cyc + 1, e.len);
            chk("dir_rise", dr, e.dr);
            chk("done_at_end", done, e.dn);
            chk("busy_gap", gaps, 0);
          end
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge that ends the fetch.
  task automatic fetch(input bit q, input logic [23:0] a, input int abort_cyc,
                       input int restart_cyc, input bit abort_with_start);
    exp_t e;
    int   c, full;
    full   = q ? 8 + 24 + 8 + BB/4 : 8 + 24 + BB;
    e.word = {q ? 8'h6B : 8'h03, a};
    e.len  = (abort_cyc >= 0) ? abort_cyc + 1 : full;
    e.dr   = (e.len > 32) ? 32 : -1;
    e.dn   = (abort_cyc < 0);
    sbq.push_back(e);
    start = 1; quad = q; addr = a; abort = abort_with_start;
    @(posedge clk); #1;
    start = 0; abort = 0; quad = ~q; addr = 24'($urandom);
    chk("busy_after_start", busy, 1);
    c = 0;
    while (busy === 1'b1 && c < 400) begin
      abort = (c == abort_cyc);
      start = (c == restart_cyc);
      @(posedge clk); #1;
      c++;
    end
    start = 0; abort = 0;
    chk("fetch_ends", c < 400, 1);
    if (e.dn) begin
      mbank[1-mdisp]  = flash_pat;
      mknown[1-mdisp] = 1;
      mdisp           = 1 - mdisp;
      exp_done++;
    end else if (abort_cyc >= 32) begin
      mknown[1-mdisp] = 0;
    end
  endtask

  task automatic readback(input string nm);
    int idx;
    for (int i = 0; i <= BB; i++) begin
      idx = (i == BB) ? 200 : i;
      rd_index = 8'(idx);
      @(posedge clk); #1;
      if (idx >= BB) chk("rd_out_of_range", rd_data, 0);
      else if (mknown[mdisp]) chk(nm, rd_data, mbank[mdisp][idx]);
    end
  endtask

  initial begin : stim
    logic [7:0]  a5;
    logic [23:0] a;
    exp_t        e;
    int          ab, full;
    bit          q;
    mknown[0] = 0; mknown[1] = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_cs", spi_cs, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out0", spi_out0, 0);
    chk("rst_dir0", spi_dir0, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1;
    @(posedge clk); #1;

    flash_pat = rand_pat();
    fetch(0, 24'h000120, -1, -1, 0);
    readback("rd_single");

    // quad line beginning with nibbles A,5; restart attempt mid-DATA; abort with start
    flash_pat = rand_pat();
    a5 = 8'hA5;
    flash_pat[BB-1 -: 8] = a5;
    fetch(1, 24'($urandom), -1, 40 + 10, 1);
    for (int i = 0; i < 8; i++) begin
      rd_index = 8'(BB - 1 - i);
      @(posedge clk); #1;
      chk("quad_a5_bits", rd_data, a5[7-i]);
    end
    readback("rd_quad");

    flash_pat = rand_pat();
    fetch(0, 24'($urandom), 32 + 50, -1, 0);
    readback("rd_after_abort");

    // reset in ADDR cycle 5 (bus cycle 13)
    flash_pat = rand_pat();
    a = 24'($urandom);
    e.word = {8'h6B, a}; e.len = 14; e.dr = -1; e.dn = 0;
    sbq.push_back(e);
    start = 1; quad = 1; addr = a;
    @(posedge clk); #1;
    start = 0;
    repeat (13) @(posedge clk);
    #3; reset = 0; #1;
    chk("cs_async_reset", spi_cs, 0);
    chk("busy_async_reset", busy, 0);
    @(posedge clk); #1;
    chk("rd_data_in_reset", rd_data, 0);
    chk("done_in_reset", done, 0);
    reset = 1; mdisp = 0;
    @(posedge clk); #1;
    flash_pat = rand_pat();
    fetch(1'($urandom), 24'($urandom), -1, -1, 0);
    readback("rd_after_reset");

    for (int t = 0; t < 2; t++) begin
      flash_pat = rand_pat();
      fetch(1'($urandom), 24'($urandom), -1, -1, 0);
      readback("rd_back_to_back");
    end

    for (int t = 0; t < 4; t++) begin
      q    = 1'($urandom);
      full = q ? 8 + 24 + 8 + BB/4 : 8 + 24 + BB;
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, full - 1)) : -1;
      flash_pat = rand_pat();
      fetch(q, 24'($urandom), ab, -1, 0);
      readback("rd_random");
    end

    repeat (5) @(posedge clk); #1;
    chk("done_count", done_seen, exp_done);
    chk("idle_io_zero", idle_err, 0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qspi_line_reader.md
QSPI_LINE_READER -- requirements
Module: qspi_line_reader

Interface
REQ-001 Parameter BUF_BITS, default 136, bits stored per line bank; SHALL be a multiple of 4.
REQ-002 Parameter DUMMY_CYCLES, default 8, SCLKs between address and data in quad mode.
REQ-003 Parameter ADDR_BITS, default 24, flash address width sent after the command.
REQ-004 clk  in  1  system clock; all logic single-clock domain.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to fetch a line; honoured only in IDLE.
REQ-007 quad  in  1  0 = single read (03h), 1 = quad output read (6Bh); sampled with start.
REQ-008 addr  in  ADDR_BITS  flash byte address; sampled with start.
REQ-009 abort  in  1  terminates an in-progress fetch.
REQ-010 busy  out  1  high from the cycle after an accepted start until the fetch ends.
REQ-011 done  out  1  one-cycle pulse after a completed (non-aborted) fetch.
REQ-012 rd_index  in  $clog2(BUF_BITS)  bit index into the display bank.
REQ-013 rd_data  out  1  registered bit of the display bank at rd_index.
REQ-014 spi_cs  out  1  chip select, active HIGH; parent inverts.
REQ-015 spi_sclk  out  1  ~clk, free-running.
REQ-016 spi_in  in  4  io[3:0] input side; io[1] is MISO in single mode.
REQ-017 spi_out0  out  1  io0 output side (MOSI).
REQ-018 spi_dir0  out  1  io0 direction, 0 = output, 1 = input.

Function
REQ-019 FSM states: IDLE, CMD (8 cycles), ADDR (ADDR_BITS cycles), DUMMY (DUMMY_CYCLES, quad only), DATA (BUF_BITS cycles single, BUF_BITS/4 quad), DONE (1 cycle) -> IDLE.
REQ-020 start in IDLE -> CMD on the next rising clk; spi_cs=1 and spi_out0=cmd[7] in the first CMD cycle.
REQ-021 start outside IDLE SHALL be ignored; quad and addr SHALL be held internally for the whole fetch.
REQ-022 spi_out0 SHALL present cmd MSB-first in CMD, then addr MSB-first in ADDR, and 0 in all other states.
REQ-023 spi_dir0 SHALL be 0 in IDLE, CMD, ADDR and DONE, and 1 in DUMMY and DATA.
REQ-024 spi_cs SHALL be 1 exactly in CMD, ADDR, DUMMY and DATA.
REQ-025 Input data SHALL be captured on the falling clk edge (rising spi_sclk) of each DATA cycle.
REQ-026 Single mode: the k-th captured bit (k=0..BUF_BITS-1) SHALL be written to write-bank index BUF_BITS-1-k.
REQ-027 Quad mode: the k-th nibble {io3,io2,io1,io0} SHALL be written to write-bank bits [BUF_BITS-1-4k -: 4].
REQ-028 Two banks ping-pong: in DONE the write and display banks swap; done=1 for that cycle only.
REQ-029 rd_data SHALL equal display_bank[rd_index] one clk after rd_index is presented; an index >= BUF_BITS SHALL return 0.
REQ-030 abort during CMD..DATA SHALL go to IDLE on the next clk with spi_cs=0, no swap and no done; the write bank contents are undefined.
REQ-031 abort and start in the same IDLE cycle: start wins, abort ignored.
REQ-032 abort and the last DATA cycle together: abort wins.
REQ-033 The display bank SHALL never be written while it is the display bank.

Reset
REQ-034 While reset=0: FSM=IDLE, spi_cs=0, spi_out0=0, spi_dir0=0, busy=0, done=0, rd_data=0, display bank=bank 0; bank contents are not reset.
REQ-035 Reset asserted mid-fetch SHALL deassert spi_cs asynchronously, without waiting for a clk edge.

Structure
REQ-036 Command codes (03h, 6Bh), FSM state encoding and io direction constants SHALL live in a shared package.
REQ-037 One sub-module, qspi_line_bank: dual-bank storage with a write port and a registered read port.

Verification
REQ-038 Single, addr=000120h -> MOSI stream 03h then 000120h; cs high 168 cycles; spi_dir0 rises at cycle 32.
REQ-039 Quad, flash model streams nibbles A,5,... -> after done, rd_index 135..128 reads 1,0,1,0,0,1,0,1; cs high 74 cycles.
REQ-040 start pulsed again at quad DATA cycle 10 -> ignored; exactly one done; busy is continuous.
REQ-041 abort at single DATA cycle 50 -> cs low next clk; no done; display bank is unchanged.
REQ-042 reset low at ADDR cycle 5 -> cs and busy are 0 immediately; start after release runs a full fetch.
REQ-043 Two back-to-back fetches of distinct patterns -> the display bank alternates, and rd_index=200 returns 0.
